fpu_add_align_stage: RTL
========================

// Module: fpu_add_align_stage
// PURPOSE
//  Operand pre-alignment stage of the FP32 adder/subtractor, upstream of the normalise/add datapath.
//  Unpacks two IEEE-754 singles and orders them by magnitude: exponent compare, then a 24-bit CLA mantissa less-than on a tie.
//  Shifts the smaller mantissa right by the exponent difference and appends guard/round/sticky bits.
//  2-stage valid/ready pipeline with backpressure.
// PARAMETERS
//  EXP_W   8   exponent width
//  MAN_W   23  stored fraction width; internal mantissa = MAN_W+1, aligned = MAN_W+4 (G,R,S)
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst         in   1   reset, asynchronous, active-high
//  i_valid       in   1   input operands valid
//  o_ready       out  1   stage can accept; transfer when i_valid & o_ready
//  i_data_a      in   32  operand A (FP32)
//  i_data_b      in   32  operand B (FP32)
//  i_sub         in   1   1 = A-B, 0 = A+B
//  o_valid       out  1   output bundle valid
//  i_ready       in   1   downstream accepts; transfer when o_valid & i_ready
//  o_swap        out  1   1 = |B| > |A| (B is the big operand)
//  o_sign_big    out  1   effective sign of big operand (B sign is XORed with i_sub)
//  o_eff_sub     out  1   sign_a ^ sign_b ^ i_sub
//  o_exp_big     out  8   biased exponent of big operand
//  o_mant_big    out  27  {hidden,frac,3'b000}
//  o_mant_small  out  27  {hidden,frac,3'b000} >> diff; LSB ORed with all shifted-out bits (sticky)
// BEHAVIOUR
//  - Reset: s1_valid=0, o_valid=0, all data registers and outputs 0; o_ready=1 once reset is released.
//  - Latency: 2 cycles from input transfer to o_valid when not stalled; throughput 1/cycle.
//  - Stage enables:
//    - en2 = ~o_valid | i_ready
//    - en1 = ~s1_valid | en2
//    - o_ready = en1 (combinational from i_ready)
//  - S1 on en1 (registers):
//    - captures s1_valid <= i_valid
//    - unpacks both operands; hidden bit = (exp!=0)
//    - swap = (ea<eb) | (ea==eb & ma<mb)
//    - diff = e_big - e_small (8-bit, never negative)
//    - equal magnitude: swap=0 (A is big)
//  - S2 on en2 (registers): s2 valid <= s1_valid; shifts the small mantissa by diff.
//    - diff >= 27: o_mant_small = {26'b0, |m_small}
//    - diff = 0: unshifted
//  - Stall: while o_valid & ~i_ready, every output holds stable; no bundle is dropped or duplicated.
//  - Order: bundles leave in acceptance order.
//  - Bubbles: a stage captures invalid data when empty, but its valid stays 0.
//  - Reset mid-operation: in-flight bundles are discarded; o_valid=0 immediately (async).
//  - NaN/Inf: not special-cased here; exp=255 passes as a normal exponent to the downstream stage.
// CONFIGURATION
//  FPU_ALIGN_DENORM_EN defined:
//    - exp=0 operands use hidden bit 0 and effective exponent 1
//    - o_exp_big reports the effective exponent
//  Not defined: exp=0 operands are flushed to zero (mantissa 0, exponent 0; sign kept).
// TESTING
//  T1: A=0x3F800000, B=0x40000000, add -> swap=1, exp_big=0x80, mant_big=0x4000000, mant_small=0x2000000, eff_sub=0.
//  T2: A=0x3FA00000, B=0x3FC00000, sub -> swap=1 (mantissa tie-break), diff 0, mant_small=0x5000000, sign_big=1, eff_sub=1.
//  T3: A=0x4B800000, B=0x3F800001 -> swap=0, mant_small=27'h5 (sticky set).
//  T3: A=0x4F800000, B=0x3F800000 -> mant_small=27'h1 (diff 32 saturates).
//  T4: i_ready=0, 3 back-to-back inputs -> 2 accepted then o_ready=0, outputs stable.
//  T4: i_ready=1 -> 3 bundles emitted in order, no gaps.
//  T5: both stages full, pulse i_rst -> o_valid=0 the same cycle, nothing emitted after release, o_ready=1.
//  T6: A=0x00000001, B=0x00000002, DENORM_EN -> swap=1, exp_big=1, mant_big=0x10, mant_small=0x8.
//  T6: same operands without DENORM_EN -> swap=0, mants 0, exp_big=0.

Source files
------------

// File: rtl/fpu_add_align_stage_if.sv
// Handshake and data bundle for the FP32 adder pre-alignment stage.
// The slave modport is the stage's view; the master modport is the producer/consumer side.
interface fpu_add_align_stage_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 4;

    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data_a;
    logic [DW-1:0] i_data_b;
    logic          i_sub;
    logic          o_valid;
    logic          i_ready;
    logic          o_swap;
    logic          o_sign_big;
    logic          o_eff_sub;
    logic [EXP_W-1:0] o_exp_big;
    logic [AW-1:0] o_mant_big;
    logic [AW-1:0] o_mant_small;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_sub, i_ready,
        output o_ready, o_valid, o_swap, o_sign_big, o_eff_sub,
               o_exp_big, o_mant_big, o_mant_small
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_sub, i_ready,
        input  o_ready, o_valid, o_swap, o_sign_big, o_eff_sub,
               o_exp_big, o_mant_big, o_mant_small
    );
endinterface

// File: rtl/fpu_add_align_stage.sv
// FP32 add/sub operand pre-alignment: magnitude ordering, then small-mantissa shift with G/R/S.
// Optional FPU_ALIGN_DENORM_EN keeps denormals (hidden 0, exponent 1) instead of flushing them to zero.
module fpu_add_align_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic i_clk,
    input logic i_rst,
    fpu_add_align_stage_if.slave bus
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int AW = MAN_W + 4;
    localparam logic [EXP_W-1:0] AW_E = EXP_W'(AW);

    // Carry-out of x + ~y + 1 via 4-bit group generate/propagate; no carry means x < y.
    function automatic logic mant_lt(input logic [MW-1:0] x, input logic [MW-1:0] y);
        logic [MW-1:0] g;
        logic [MW-1:0] p;
        logic c, gg, gp;
        g = x & ~y;
        p = x | ~y;
        c = 1'b1;
        for (int base = 0; base < MW; base += 4) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (base + k < MW) begin
                    gg = g[base+k] | (p[base+k] & gg);
                    gp = gp & p[base+k];
                end
            end
            c = gg | (gp & c);
        end
        return ~c;
    endfunction

    function automatic logic [EXP_W-1:0] unpack_exp(input logic [DW-1:0] v);
        logic [EXP_W-1:0] e;
        e = v[DW-2:MAN_W];
`ifdef FPU_ALIGN_DENORM_EN
        return (e == '0) ? EXP_W'(1) : e;
`else
        return e;
`endif
    endfunction

    function automatic logic [MW-1:0] unpack_mant(input logic [DW-1:0] v);
        logic hidden;
        hidden = (v[DW-2:MAN_W] != '0);
`ifdef FPU_ALIGN_DENORM_EN
        return {hidden, v[MAN_W-1:0]};
`else
        return hidden ? {1'b1, v[MAN_W-1:0]} : '0;
`endif
    endfunction

    logic en1, en2;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_swap_q, s1_swap_d;
    logic             s1_sign_big_q, s1_sign_big_d;
    logic             s1_eff_sub_q, s1_eff_sub_d;
    logic [EXP_W-1:0] s1_exp_big_q, s1_exp_big_d;
    logic [EXP_W-1:0] s1_diff_q, s1_diff_d;
    logic [MW-1:0]    s1_mant_big_q, s1_mant_big_d;
    logic [MW-1:0]    s1_mant_small_q, s1_mant_small_d;

    logic             o_valid_q, o_valid_d;
    logic             o_swap_q, o_swap_d;
    logic             o_sign_big_q, o_sign_big_d;
    logic             o_eff_sub_q, o_eff_sub_d;
    logic [EXP_W-1:0] o_exp_big_q, o_exp_big_d;
    logic [AW-1:0]    o_mant_big_q, o_mant_big_d;
    logic [AW-1:0]    o_mant_small_q, o_mant_small_d;

    assign en2 = ~o_valid_q | bus.i_ready;
    assign en1 = ~s1_valid_q | en2;

    // Stage 1: unpack and order by magnitude.
    always_comb begin
        logic             sa, sb, swap;
        logic [EXP_W-1:0] ea, eb;
        logic [MW-1:0]    ma, mb;
        sa   = bus.i_data_a[DW-1];
        sb   = bus.i_data_b[DW-1];
        ea   = unpack_exp(bus.i_data_a);
        eb   = unpack_exp(bus.i_data_b);
        ma   = unpack_mant(bus.i_data_a);
        mb   = unpack_mant(bus.i_data_b);
        swap = (ea < eb) | ((ea == eb) & mant_lt(ma, mb));

        s1_valid_d      = s1_valid_q;
        s1_swap_d       = s1_swap_q;
        s1_sign_big_d   = s1_sign_big_q;
        s1_eff_sub_d    = s1_eff_sub_q;
        s1_exp_big_d    = s1_exp_big_q;
        s1_diff_d       = s1_diff_q;
        s1_mant_big_d   = s1_mant_big_q;
        s1_mant_small_d = s1_mant_small_q;
        if (en1) begin
            s1_valid_d      = bus.i_valid;
            s1_swap_d       = swap;
            s1_sign_big_d   = swap ? (sb ^ bus.i_sub) : sa;
            s1_eff_sub_d    = sa ^ sb ^ bus.i_sub;
            s1_exp_big_d    = swap ? eb : ea;
            s1_diff_d       = swap ? (eb - ea) : (ea - eb);
            s1_mant_big_d   = swap ? mb : ma;
            s1_mant_small_d = swap ? ma : mb;
        end
    end

    // Stage 2: right-shift the small mantissa, folding every lost bit into the sticky LSB.
    always_comb begin
        logic [AW-1:0] full, shifted;
        full    = {s1_mant_small_q, 3'b000};
        shifted = '0;
        if (s1_diff_q >= AW_E) begin
            shifted = AW'(|s1_mant_small_q);
        end else begin
            shifted    = full >> s1_diff_q;
            shifted[0] = shifted[0] | (|(full & ~({AW{1'b1}} << s1_diff_q)));
        end

        o_valid_d      = o_valid_q;
        o_swap_d       = o_swap_q;
        o_sign_big_d   = o_sign_big_q;
        o_eff_sub_d    = o_eff_sub_q;
        o_exp_big_d    = o_exp_big_q;
        o_mant_big_d   = o_mant_big_q;
        o_mant_small_d = o_mant_small_q;
        if (en2) begin
            o_valid_d      = s1_valid_q;
            o_swap_d       = s1_swap_q;
            o_sign_big_d   = s1_sign_big_q;
            o_eff_sub_d    = s1_eff_sub_q;
            o_exp_big_d    = s1_exp_big_q;
            o_mant_big_d   = {s1_mant_big_q, 3'b000};
            o_mant_small_d = shifted;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q      <= 1'b0;
            s1_swap_q       <= 1'b0;
            s1_sign_big_q   <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_exp_big_q    <= '0;
            s1_diff_q       <= '0;
            s1_mant_big_q   <= '0;
            s1_mant_small_q <= '0;
            o_valid_q       <= 1'b0;
            o_swap_q        <= 1'b0;
            o_sign_big_q    <= 1'b0;
            o_eff_sub_q     <= 1'b0;
            o_exp_big_q     <= '0;
            o_mant_big_q    <= '0;
            o_mant_small_q  <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_swap_q       <= s1_swap_d;
            s1_sign_big_q   <= s1_sign_big_d;
            s1_eff_sub_q    <= s1_eff_sub_d;
            s1_exp_big_q    <= s1_exp_big_d;
            s1_diff_q       <= s1_diff_d;
            s1_mant_big_q   <= s1_mant_big_d;
            s1_mant_small_q <= s1_mant_small_d;
            o_valid_q       <= o_valid_d;
            o_swap_q        <= o_swap_d;
            o_sign_big_q    <= o_sign_big_d;
            o_eff_sub_q     <= o_eff_sub_d;
            o_exp_big_q     <= o_exp_big_d;
            o_mant_big_q    <= o_mant_big_d;
            o_mant_small_q  <= o_mant_small_d;
        end
    end

    assign bus.o_ready      = en1;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_swap       = o_swap_q;
    assign bus.o_sign_big   = o_sign_big_q;
    assign bus.o_eff_sub    = o_eff_sub_q;
    assign bus.o_exp_big    = o_exp_big_q;
    assign bus.o_mant_big   = o_mant_big_q;
    assign bus.o_mant_small = o_mant_small_q;
endmodule
